// File: rtl/rib_uart_tx_pkg.sv
// Shared definitions for the RIB UART transmitter: register offsets, bit indices, FSM states.
// Optional parity support is selected with the UART_TX_PARITY_EN macro.
package rib_uart_tx_pkg;

  localparam logic [1:0] REG_CTRL   = 2'd0;
  localparam logic [1:0] REG_STATUS = 2'd1;
  localparam logic [1:0] REG_BAUD   = 2'd2;
  localparam logic [1:0] REG_TXDATA = 2'd3;

  localparam int CTRL_TX_EN      = 0;
  localparam int CTRL_PARITY_ODD = 2;

  localparam int ST_BUSY     = 0;
  localparam int ST_FULL     = 1;
  localparam int ST_EMPTY    = 2;
  localparam int ST_DONE     = 3;
  localparam int ST_OVERFLOW = 4;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4
  } tx_state_t;

  // Bit periods shorter than two cycles are clamped to two.
  function automatic logic [15:0] eff_baud(input logic [15:0] baud);
    return (baud < 16'd2) ? 16'd2 : baud;
  endfunction

endpackage

// File: rtl/rib_uart_tx_fifo.sv
// Synchronous byte FIFO with first-word-fall-through read; a push while full is
// accepted only when a pop frees a slot in the same cycle.
module rib_uart_tx_fifo #(
  parameter int FIFO_DEPTH = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       push,
  input  logic       pop,
  input  logic [7:0] wdata,
  output logic [7:0] rdata,
  output logic       full,
  output logic       empty
);

  localparam int AW = $clog2(FIFO_DEPTH);

  logic [7:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_reg;
  logic [AW-1:0] rd_ptr_reg;
  logic [AW:0]   count_reg;
  logic          do_push;
  logic          do_pop;

  assign full    = (count_reg == (AW+1)'(FIFO_DEPTH));
  assign empty   = (count_reg == '0);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign rdata   = mem[rd_ptr_reg];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr_reg] <= wdata;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (do_push) wr_ptr_reg <= wr_ptr_reg + AW'(1);
      if (do_pop)  rd_ptr_reg <= rd_ptr_reg + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count_reg <= count_reg + (AW+1)'(1);
        2'b01:   count_reg <= count_reg - (AW+1)'(1);
        default: count_reg <= count_reg;
      endcase
    end
  end

endmodule

// File: rtl/rib_uart_tx.sv
// RIB-bus buffered UART transmitter (8N1, or 8E1/8O1 when UART_TX_PARITY_EN is defined).
// Register decode, FIFO, bit timing and frame FSM; tx_o is registered.
module rib_uart_tx
  import rib_uart_tx_pkg::*;
#(
  parameter int          FIFO_DEPTH   = 16,
  parameter logic [15:0] BAUD_DEFAULT = 16'd434
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_i,
  input  logic        we_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] data_i,
  output logic [31:0] data_o,
  output logic        tx_o,
  output logic        tx_done_o
);

  tx_state_t   state_reg, state_next;
  logic        tx_en_reg;
  logic [15:0] baud_reg;
  logic        done_reg;
  logic        overflow_reg;
  logic [15:0] bit_cnt_reg;
  logic [15:0] bit_len_reg;
  logic [2:0]  bit_idx_reg;
  logic [7:0]  shift_reg;
  logic        tx_reg;
  logic        tx_done_reg;
`ifdef UART_TX_PARITY_EN
  logic        parity_odd_reg;
  logic        parity_reg;
`endif

  logic        wr, rd, push, pop, load, done_set, line, bit_done, busy;
  logic [1:0]  sel;
  logic [7:0]  fifo_rdata;
  logic        fifo_full, fifo_empty;
  logic [31:0] read_data;
  logic        unused_bits;

  assign sel         = addr_i[3:2];
  assign wr          = req_i && we_i;
  assign rd          = req_i && !we_i;
  assign push        = wr && (sel == REG_TXDATA);
  assign bit_done    = (bit_cnt_reg == bit_len_reg - 16'd1);
  assign busy        = (state_reg != S_IDLE) || !fifo_empty;
  assign unused_bits = ^{addr_i[31:4], addr_i[1:0], data_i[31:16]};

  rib_uart_tx_fifo #(.FIFO_DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .wdata (data_i[7:0]),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_ff @(posedge clk) begin
    if (!rst) state_reg <= S_IDLE;
    else      state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    pop        = 1'b0;
    load       = 1'b0;
    done_set   = 1'b0;
    line       = 1'b1;
    case (state_reg)
      S_IDLE: begin
        if (tx_en_reg && !fifo_empty) begin
          pop        = 1'b1;
          load       = 1'b1;
          state_next = S_START;
        end
      end
      S_START: begin
        line = 1'b0;
        if (bit_done) state_next = S_DATA;
      end
      S_DATA: begin
        line = shift_reg[0];
        if (bit_done && bit_idx_reg == 3'd7)
`ifdef UART_TX_PARITY_EN
          state_next = S_PARITY;
`else
          state_next = S_STOP;
`endif
      end
`ifdef UART_TX_PARITY_EN
      S_PARITY: begin
        line = parity_reg;
        if (bit_done) state_next = S_STOP;
      end
`endif
      S_STOP: begin
        // Chain straight into the next frame so queued bytes leave with no idle gap.
        if (bit_done) begin
          if (tx_en_reg && !fifo_empty) begin
            pop        = 1'b1;
            load       = 1'b1;
            state_next = S_START;
          end else begin
            state_next = S_IDLE;
            done_set   = 1'b1;
          end
        end
      end
      default: state_next = S_IDLE;
    endcase
  end

  // Bit length is latched at each bit boundary so BAUD changes take effect on the next bit.
  always_ff @(posedge clk) begin
    if (!rst) begin
      bit_cnt_reg <= '0;
      bit_len_reg <= 16'd2;
      bit_idx_reg <= '0;
      shift_reg   <= '0;
      tx_reg      <= 1'b1;
      tx_done_reg <= 1'b0;
`ifdef UART_TX_PARITY_EN
      parity_reg  <= 1'b0;
`endif
    end else begin
      tx_reg      <= line;
      tx_done_reg <= done_set;
      if (load) begin
        shift_reg   <= fifo_rdata;
        bit_cnt_reg <= '0;
        bit_len_reg <= eff_baud(baud_reg);
        bit_idx_reg <= '0;
`ifdef UART_TX_PARITY_EN
        parity_reg  <= (^fifo_rdata) ^ parity_odd_reg;
`endif
      end else if (state_reg != S_IDLE) begin
        if (bit_done) begin
          bit_cnt_reg <= '0;
          bit_len_reg <= eff_baud(baud_reg);
          if (state_reg == S_DATA) begin
            shift_reg   <= {1'b0, shift_reg[7:1]};
            bit_idx_reg <= bit_idx_reg + 3'd1;
          end
        end else begin
          bit_cnt_reg <= bit_cnt_reg + 16'd1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      tx_en_reg      <= 1'b0;
      baud_reg       <= BAUD_DEFAULT;
      done_reg       <= 1'b0;
      overflow_reg   <= 1'b0;
`ifdef UART_TX_PARITY_EN
      parity_odd_reg <= 1'b0;
`endif
    end else begin
      if (wr && sel == REG_CTRL) begin
        tx_en_reg      <= data_i[CTRL_TX_EN];
`ifdef UART_TX_PARITY_EN
        parity_odd_reg <= data_i[CTRL_PARITY_ODD];
`endif
      end
      if (wr && sel == REG_BAUD) baud_reg <= data_i[15:0];
      // Set beats a simultaneous W1C clear.
      if (wr && sel == REG_STATUS && data_i[ST_DONE])     done_reg     <= 1'b0;
      if (wr && sel == REG_STATUS && data_i[ST_OVERFLOW]) overflow_reg <= 1'b0;
      if (done_set) done_reg <= 1'b1;
      if (push && fifo_full && !pop) overflow_reg <= 1'b1;
    end
  end

  always_comb begin
    read_data = '0;
    if (rd) begin
      case (sel)
        REG_CTRL: begin
          read_data[CTRL_TX_EN] = tx_en_reg;
`ifdef UART_TX_PARITY_EN
          read_data[CTRL_PARITY_ODD] = parity_odd_reg;
`endif
        end
        REG_STATUS: begin
          read_data[ST_BUSY]     = busy;
          read_data[ST_FULL]     = fifo_full;
          read_data[ST_EMPTY]    = fifo_empty;
          read_data[ST_DONE]     = done_reg;
          read_data[ST_OVERFLOW] = overflow_reg;
        end
        REG_BAUD: read_data[15:0] = baud_reg;
        default:  read_data = '0;
      endcase
    end
  end

  assign data_o    = read_data;
  assign tx_o      = tx_reg;
  assign tx_done_o = tx_done_reg;

endmodule

// File: tb/tb_rib_uart_tx.sv
// Self-checking bench for rib_uart_tx: register table, directed frame sequences and
// randomized frames checked against a bit-level model of the serial line.
module tb_rib_uart_tx;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        req = 1'b0;
  logic        we = 1'b0;
  logic [31:0] addr = '0;
  logic [31:0] wdata = '0;
  logic [31:0] rdata;
  logic        tx;
  logic        tx_done;

  int errors = 0;
  int checks = 0;
  logic par_odd = 1'b0;

`ifdef UART_TX_PARITY_EN
  localparam int FL = 11;
`else
  localparam int FL = 10;
`endif

  rib_uart_tx dut (
    .clk       (clk),
    .rst       (rst),
    .req_i     (req),
    .we_i      (we),
    .addr_i    (addr),
    .data_i    (wdata),
    .data_o    (rdata),
    .tx_o      (tx),
    .tx_done_o (tx_done)
  );

  always #5 clk = ~clk;

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1, "watchdog");
  end

  logic cap_en = 1'b0;
  logic trace_q[$];
  logic done_q[$];

  always @(negedge clk) begin
    if (cap_en) begin
      trace_q.push_back(tx);
      done_q.push_back(tx_done);
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
    end
  endtask

  task automatic bus_write(input logic [3:0] a, input logic [31:0] d);
    req = 1'b1; we = 1'b1;
    addr = ($urandom() & 32'hFFFF_FFF0) | {28'h0, a};
    wdata = d;
    @(posedge clk); #1;
    req = 1'b0; we = 1'b0; wdata = '0;
  endtask

  task automatic bus_read(input logic [3:0] a, output logic [31:0] d);
    req = 1'b1; we = 1'b0;
    addr = ($urandom() & 32'hFFFF_FFF0) | {28'h0, a};
    @(negedge clk);
    d = rdata;
    @(posedge clk); #1;
    req = 1'b0;
  endtask

  task automatic begin_capture();
    trace_q.delete();
    done_q.delete();
    cap_en = 1'b1;
  endtask

  // Serial frame model: start 0, eight data bits LSB first, optional parity, stop 1.
  function automatic logic frame_bit(input logic [7:0] b, input int k);
    if (k == 0) return 1'b0;
    if (k <= 8) return b[k-1];
    if (k == 9 && FL == 11) return (^b) ^ par_odd;
    return 1'b1;
  endfunction

  task automatic check_capture(input logic [7:0] bytes[$], input int baud, input string name);
    logic exp_q[$];
    int eb, endi, guard, first0, bad, dcount, didx, lo, hi;
    eb = (baud < 2) ? 2 : baud;
    exp_q = {1'b1, 1'b1};
    foreach (bytes[f])
      for (int k = 0; k < FL; k++)
        for (int c = 0; c < eb; c++) exp_q.push_back(frame_bit(bytes[f], k));
    endi = exp_q.size();
    for (int i = 0; i < 8; i++) exp_q.push_back(1'b1);
    guard = 0;
    while (trace_q.size() < exp_q.size() && guard < exp_q.size() + 100) begin
      @(posedge clk);
      guard++;
    end
    cap_en = 1'b0;
    chk({name, " capture length ok"}, 32'(trace_q.size() >= exp_q.size()), 32'd1);
    if (trace_q.size() < exp_q.size()) return;
    first0 = -1;
    for (int i = 0; i < trace_q.size(); i++)
      if (trace_q[i] === 1'b0) begin first0 = i; break; end
    chk({name, " start latency"}, 32'(first0), 32'd2);
    for (int f = 0; f <= bytes.size(); f++) begin
      lo = (f == 0) ? 0 : 2 + f * FL * eb;
      hi = (f == bytes.size()) ? exp_q.size() : 2 + (f + 1) * FL * eb;
      bad = 0;
      for (int i = lo; i < hi; i++) if (trace_q[i] !== exp_q[i]) bad++;
      chk($sformatf("%s seg%0d mismatched cycles", name, f), 32'(bad), 32'd0);
    end
    dcount = 0; didx = -1;
    for (int i = 0; i < done_q.size(); i++)
      if (done_q[i] === 1'b1) begin
        dcount++;
        if (didx < 0) didx = i;
      end
    chk({name, " tx_done pulses"}, 32'(dcount), 32'd1);
    chk({name, " tx_done at end of last stop"}, 32'(didx >= endi - 1 && didx <= endi), 32'd1);
  endtask

  task automatic send(input logic [7:0] bytes[$], input int baud, input string name);
    bus_write(4'hC, {24'h0, bytes[0]});
    begin_capture();
    for (int i = 1; i < bytes.size(); i++) bus_write(4'hC, {$urandom_range(0, 255) << 8, bytes[i]});
    check_capture(bytes, baud, name);
  endtask

  typedef struct packed {
    logic        we;
    logic [3:0]  a;
    logic [31:0] d;
    logic [31:0] exp;
  } vec_t;

  vec_t vt[14];

  initial begin
    logic [31:0] r;
    logic [7:0]  q[$];
    int baud, n, lowcnt, dcnt;

    vt[0]  = '{1'b0, 4'h0, 32'h0, 32'h0};
    vt[1]  = '{1'b0, 4'h4, 32'h0, 32'h4};
    vt[2]  = '{1'b0, 4'h8, 32'h0, 32'd434};
    vt[3]  = '{1'b0, 4'hC, 32'h0, 32'h0};
    vt[4]  = '{1'b1, 4'h8, 32'hFFFF_0007, 32'h0};
    vt[5]  = '{1'b0, 4'h8, 32'h0, 32'h7};
    vt[6]  = '{1'b1, 4'h8, 32'h0, 32'h0};
    vt[7]  = '{1'b0, 4'h8, 32'h0, 32'h0};
    vt[8]  = '{1'b1, 4'h0, 32'hFFFF_FFFF, 32'h0};
    vt[9]  = '{1'b0, 4'h0, 32'h0, (FL == 11) ? 32'h5 : 32'h1};
    vt[10] = '{1'b1, 4'h0, 32'h0, 32'h0};
    vt[11] = '{1'b0, 4'h0, 32'h0, 32'h0};
    vt[12] = '{1'b1, 4'h4, 32'hFFFF_FFFF, 32'h0};
    vt[13] = '{1'b0, 4'h4, 32'h0, 32'h4};

    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    chk("reset tx_o", 32'(tx), 32'd1);
    chk("reset tx_done_o", 32'(tx_done), 32'd0);
    chk("data_o idle", rdata, 32'h0);

    foreach (vt[i]) begin
      if (vt[i].we) bus_write(vt[i].a, vt[i].d);
      else begin
        bus_read(vt[i].a, r);
        chk($sformatf("regvec%0d addr 0x%0h", i, vt[i].a), r, vt[i].exp);
      end
    end

    // 0x55 at 4 cycles per bit
    bus_write(4'h8, 32'd4);
    bus_write(4'h0, 32'd1);
    q = {8'h55};
    send(q, 4, "t1_0x55");
    bus_read(4'h4, r);
    chk("t1 status after drain", r, 32'h0C);

    q = {8'hA1, 8'hB2, 8'hC3};
    bus_write(4'h8, 32'd3);
    send(q, 3, "t2_b2b");

    // BAUD 0 and 1 clamp to two cycles per bit
    bus_write(4'h8, 32'd0);
    bus_read(4'h8, r);
    chk("t4 baud0 readback", r, 32'h0);
    q = {8'h3C};
    send(q, 0, "t4_baud0");
    bus_write(4'h8, 32'd1);
    bus_read(4'h8, r);
    chk("t4 baud1 readback", r, 32'h1);
    q = {8'hC3, 8'h0F};
    send(q, 1, "t4_baud1");

    for (int it = 0; it < 8; it++) begin
      baud = $urandom_range(0, 6);
      n = $urandom_range(1, 4);
      q.delete();
      for (int i = 0; i < n; i++) q.push_back(8'($urandom_range(0, 255)));
      bus_write(4'h8, {16'($urandom()), 16'(baud)});
      send(q, baud, $sformatf("rand%0d", it));
    end

    // Fill while disabled, overflow, clear overflow, then drain
    bus_write(4'h0, 32'd0);
    bus_write(4'h4, 32'h18);
    q.delete();
    for (int i = 0; i < 16; i++) begin
      q.push_back(8'($urandom_range(0, 255)));
      bus_write(4'hC, {24'h0, q[i]});
    end
    bus_write(4'hC, 32'hEE);
    bus_read(4'h4, r);
    chk("t3 status full+overflow", r & 32'h1E, 32'h12);
    bus_write(4'h4, 32'h10);
    bus_read(4'h4, r);
    chk("t3 status after overflow clear", r & 32'h1E, 32'h02);
    bus_write(4'h8, 32'd2);
    bus_write(4'h0, 32'd1);
    begin_capture();
    check_capture(q, 2, "t3_drain");

    // Reset during data bit 3
    bus_write(4'h8, 32'd4);
    bus_write(4'hC, 32'h00);
    repeat (20) @(negedge clk);
    chk("t5 line low before reset", 32'(tx), 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    chk("t5 tx_o after reset", 32'(tx), 32'd1);
    lowcnt = 0; dcnt = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (tx !== 1'b1) lowcnt++;
      if (tx_done !== 1'b0) dcnt++;
    end
    chk("t5 line stays idle", 32'(lowcnt), 32'd0);
    chk("t5 no tx_done", 32'(dcnt), 32'd0);
    bus_read(4'h4, r);
    chk("t5 status", r, 32'h04);
    bus_read(4'h8, r);
    chk("t5 baud", r, 32'd434);

`ifdef UART_TX_PARITY_EN
    bus_write(4'h8, 32'd3);
    bus_write(4'h0, 32'd1);
    par_odd = 1'b0;
    q = {8'h07};
    send(q, 3, "t6_even");
    chk("t6 even parity bit", 32'(trace_q[2 + 9 * 3 + 1]), 32'd1);
    bus_write(4'h0, 32'd5);
    par_odd = 1'b1;
    send(q, 3, "t6_odd");
    chk("t6 odd parity bit", 32'(trace_q[2 + 9 * 3 + 1]), 32'd0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
